// File: rtl/enc8_3_handshake.sv
// rtl/enc8_3_handshake.sv - registered 8-to-3 request encoder with valid/ready handshake
// Optional ENC_RR_PRIORITY_EN selects round-robin priority instead of fixed (bit 7 highest).
module enc8_3_handshake #(
  parameter logic [2:0] RESET_CODE = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] i,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       idle
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PRESENT = 1'b1;

  logic       state;
  logic [7:0] pending;
  logic [2:0] code;
  logic [3:0] cnt;
  logic       ack;
  logic [7:0] clear_mask;
  logic [7:0] pend_eff;
  logic [2:0] next_code;
  logic [3:0] eff_cnt;

  assign ack        = (state == ST_PRESENT) && ready;
  assign clear_mask = ack ? (8'h01 << code) : 8'h00;
  // A bit re-requested in the acknowledged cycle survives because the set is OR-ed in last.
  assign pend_eff   = (pending & ~clear_mask) | (en ? i : 8'h00);

`ifdef ENC_RR_PRIORITY_EN
  logic [2:0] ptr;
  logic [2:0] start;
  logic [2:0] idx;
  logic       found;

  // On ack the search already starts just above the index being retired.
  assign start = ack ? code + 3'd1 : ptr;

  always_comb begin
    next_code = 3'd0;
    found     = 1'b0;
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = start - k[2:0];
      if (!found && pend_eff[idx]) begin
        next_code = idx;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 3'b111;
    end else if (ack) begin
      ptr <= code + 3'd1;
    end
  end
`else
  always_comb begin
    next_code = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pend_eff[k]) begin
        next_code = k[2:0];
      end
    end
  end
`endif

  always_comb begin
    eff_cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      eff_cnt = eff_cnt + {3'b000, pend_eff[k]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= 8'h00;
      code    <= RESET_CODE;
      cnt     <= 4'd0;
    end else begin
      pending <= pend_eff;
      cnt     <= eff_cnt;
      case (state)
        ST_IDLE: begin
          if (pend_eff != 8'h00) begin
            code  <= next_code;
            state <= ST_PRESENT;
          end else begin
            code <= RESET_CODE;
          end
        end
        default: begin
          // Presented code is held until accepted, even if a higher request arrives.
          if (ack) begin
            if (pend_eff != 8'h00) begin
              code <= next_code;
            end else begin
              code  <= RESET_CODE;
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign {a, b, c} = code;
  assign valid     = (state == ST_PRESENT);
  assign pend_cnt  = cnt;
  assign idle      = (pending == 8'h00);

endmodule

// File: tb/tb_enc8_3_handshake.sv
// tb/tb_enc8_3_handshake.sv - self-checking bench for enc8_3_handshake
// Honours ENC_RR_PRIORITY_EN in its reference model.
module tb_enc8_3_handshake;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] i;
  logic       ready;
  logic       a, b, c, valid, idle;
  logic [3:0] pend_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_code;
  logic [2:0] m_ptr;

  typedef struct {
    logic       en;
    logic [7:0] i;
    logic       ready;
    logic       v;
    logic [2:0] code;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[20];

  enc8_3_handshake dut (
    .clk(clk), .rst(rst), .en(en), .i(i), .ready(ready),
    .a(a), .b(b), .c(c), .valid(valid), .pend_cnt(pend_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {valid, a, b, c, pend_cnt, idle};
  endfunction

  function automatic logic [8:0] pack(input logic v, input logic [2:0] cd, input logic [3:0] n);
    return {v, cd, n, (n == 4'd0)};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b code=%0d cnt=%0d idle=%0b, expected valid=%0b code=%0d cnt=%0d idle=%0b",
               name, act[8], act[7:5], act[4:1], act[0], exp[8], exp[7:5], exp[4:1], exp[0]);
    end
  endtask

  // Highest-priority pending index: fixed (7 down to 0) or round-robin from the pointer downward.
  function automatic logic [2:0] m_prio(input logic [7:0] p, input logic [2:0] ptr);
`ifdef ENC_RR_PRIORITY_EN
    for (int s = 0; s < 8; s++) begin
      int bi;
      bi = (int'(ptr) + 8 - s) % 8;
      if (p[bi]) return 3'(bi);
    end
`else
    for (int bi = 7; bi >= 0; bi--) if (p[bi]) return 3'(bi);
`endif
    return 3'd0;
  endfunction

  function automatic logic [8:0] model_vec();
    return pack(m_valid, m_code, 4'($countones(m_pend)));
  endfunction

  task automatic model_reset();
    m_pend  = 8'h00;
    m_valid = 1'b0;
    m_code  = 3'd0;
    m_ptr   = 3'b111;
  endtask

  task automatic model_step(input logic e, input logic [7:0] iv, input logic r);
    logic       acc;
    logic [7:0] eff;
    acc = m_valid && r;
    eff = m_pend;
    if (acc) begin
      eff[m_code] = 1'b0;
      m_ptr = m_code + 3'd1;
    end
    if (e) eff = eff | iv;
    if (!m_valid || acc) begin
      if (eff != 8'h00) begin
        m_valid = 1'b1;
        m_code  = m_prio(eff, m_ptr);
      end else begin
        m_valid = 1'b0;
        m_code  = 3'd0;
      end
    end
    m_pend = eff;
  endtask

  task automatic cyc(input logic e, input logic [7:0] iv, input logic r, input string name);
    en = e; i = iv; ready = r;
    @(posedge clk);
    model_step(e, iv, r);
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h81, 1'b1, 1'b1, 3'd7, 4'd2};
    tbl[1]  = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 4'd1};
    tbl[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 4'd0};
    tbl[3]  = '{1'b1, 8'h20, 1'b0, 1'b1, 3'd5, 4'd1};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd5, 4'd1};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd5, 4'd1};
    tbl[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 4'd0};
    tbl[7]  = '{1'b1, 8'h08, 1'b0, 1'b1, 3'd3, 4'd1};
    tbl[8]  = '{1'b1, 8'h80, 1'b0, 1'b1, 3'd3, 4'd2};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd7, 4'd1};
    tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 4'd0};
    tbl[11] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd2, 4'd1};
    tbl[12] = '{1'b1, 8'h04, 1'b1, 1'b1, 3'd2, 4'd1};
    tbl[13] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 4'd0};
    for (int k = 14; k < 19; k++) tbl[k] = '{1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 4'd0};
    tbl[19] = '{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 4'd0};

    rst = 1'b1; en = 1'b1; i = 8'hFF; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", dut_vec(), pack(1'b0, 3'd0, 4'd0));
    rst = 1'b0;

    cyc(1'b1, 8'hFF, 1'b0, "first_after_reset");
    check("all_pending", dut_vec(), pack(1'b1, 3'd7, 4'd8));

    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 8'h00, 1'b1, "drain_model");
      check("drain_cnt", {5'd0, pend_cnt}, {5'd0, 4'(7 - k)});
    end
    check("drain_done", {8'd0, valid}, 9'd0);

    for (int k = 0; k < 20; k++) begin
      en = tbl[k].en; i = tbl[k].i; ready = tbl[k].ready;
      @(posedge clk);
      model_step(tbl[k].en, tbl[k].i, tbl[k].ready);
      #1;
      check($sformatf("tbl[%0d]", k), dut_vec(), pack(tbl[k].v, tbl[k].code, tbl[k].cnt));
      check($sformatf("tbl_model[%0d]", k), dut_vec(), model_vec());
    end

    cyc(1'b1, 8'h10, 1'b0, "pre_async_rst");
    check("present_before_rst", dut_vec(), pack(1'b1, 3'd4, 4'd1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mid_cycle", dut_vec(), pack(1'b0, 3'd0, 4'd0));
    model_reset();
    @(posedge clk);
    #1;
    check("held_in_rst", dut_vec(), pack(1'b0, 3'd0, 4'd0));
    rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 9) != 0), 8'($urandom & $urandom & $urandom),
          ($urandom_range(0, 2) != 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
